el2_ifu_fetch_buf_aln: RTL and testbench

- Fetch-buffer and instruction aligner at the receiving end of the fetch pipe.
- Captures each valid F-stage fetch group (32 bits, 2 halfwords) into a 4-entry FIFO.
- Extracts up to two RV32IC instructions per cycle (i0, i1), with halfword-granular alignment across entry boundaries.
- Reports entries retired to the fetch controller on fb_consume1/fb_consume2, which keeps that controller's one-hot mass-balance model exact.

---
 rtl/el2_ifu_pkg.sv | 38 +++
 rtl/el2_ifu_aln_extract.sv | 98 +++++++++
 rtl/el2_ifu_fetch_buf_aln.sv | 146 ++++++++++++++
 tb/tb_el2_ifu_fetch_buf_aln.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/el2_ifu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : el2_ifu_pkg
//  Description : Shared types and helpers for the IFU fetch buffer / aligner.
//  Revision    : 1.0  initial release
// ============================================================================
package el2_ifu_pkg;

    // Fetch-buffer geometry; depth must match the fetch controller's
    // fb_write width so its one-hot occupancy model stays exact.
    localparam int FB_DEPTH = 4;
    localparam int FB_PTR_W = 2;

    // One captured fetch group. hv is always a suffix mask (00, 10 or 11):
    // halfwords are only ever removed from the low end.
    typedef struct packed {
        logic [31:0] data;
        logic [29:0] pc;
        logic [1:0]  hv;
        logic        err;
    } fb_entry_t;

    // One halfword of the aligner's flattened stream.
    typedef struct packed {
        logic [15:0] hw;
        logic [30:0] pc;
        logic        err;
        logic [1:0]  ent;
        logic        v;
    } aln_hw_t;

    // A halfword starts a compressed instruction unless its low bits are 11.
    function automatic logic is_rvc(input logic [1:0] lsb);
        return lsb != 2'b11;
    endfunction

endpackage
`default_nettype wire

// File: rtl/el2_ifu_aln_extract.sv
`default_nettype none
// ============================================================================
//  Module      : el2_ifu_aln_extract
//  Description : Combinational instruction extractor. Flattens a 3-entry
//                window into a halfword stream, forms i0/i1 and reports how
//                many halfwords of each window entry the decoder takes.
//  Revision    : 1.0  initial release
// ============================================================================
module el2_ifu_aln_extract
    import el2_ifu_pkg::*;
(
    input  fb_entry_t [2:0]       i_win,
    input  logic                  i_i0_take,
    input  logic                  i_i1_take,
    input  logic                  i_hold,
    output logic                  o_i0_valid,
    output logic [31:0]           o_i0_instr,
    output logic [30:0]           o_i0_pc,
    output logic                  o_i0_is16,
    output logic                  o_i0_fault,
    output logic                  o_i1_valid,
    output logic [31:0]           o_i1_instr,
    output logic [30:0]           o_i1_pc,
    output logic                  o_i1_is16,
    output logic                  o_i1_fault,
    output logic [2:0][1:0]       o_used
);

    aln_hw_t    w_hw [4];
    aln_hw_t    w_a;
    aln_hw_t    w_b;
    logic [2:0] w_len0;
    logic [2:0] w_len1;
    logic [2:0] w_e0_cnt;
    logic [2:0] w_taken;
    logic       w_take0;
    logic       w_take1;

    // Pack the valid halfwords of the window, in order, into the first four stream slots.
    always_comb begin : p_stream
        logic [2:0] w_pos;
        for (int j = 0; j < 4; j++) begin
            w_hw[j] = '0;
        end
        w_pos = '0;
        for (int k = 0; k < 3; k++) begin
            for (int h = 0; h < 2; h++) begin
                if (i_win[k].hv[h] && (w_pos < 3'd4)) begin
                    w_hw[w_pos[1:0]].hw  = i_win[k].data[16*h +: 16];
                    w_hw[w_pos[1:0]].pc  = {i_win[k].pc, 1'(h)};
                    w_hw[w_pos[1:0]].err = i_win[k].err;
                    w_hw[w_pos[1:0]].ent = 2'(k);
                    w_hw[w_pos[1:0]].v   = 1'b1;
                    w_pos = w_pos + 3'd1;
                end
            end
        end
    end

    // i0 always starts at stream slot 0; a 32-bit opcode needs slot 1 too.
    assign o_i0_is16  = is_rvc(w_hw[0].hw[1:0]);
    assign o_i0_valid = w_hw[0].v & (o_i0_is16 | w_hw[1].v);
    assign o_i0_fault = w_hw[0].err | (~o_i0_is16 & w_hw[1].err);
    assign o_i0_pc    = w_hw[0].pc;
    assign o_i0_instr = o_i0_is16 ? {16'h0000, w_hw[0].hw} : {w_hw[1].hw, w_hw[0].hw};
    assign w_len0     = o_i0_is16 ? 3'd1 : 3'd2;

    // i1 starts right after i0; it is suppressed behind a faulted i0.
    assign w_a        = o_i0_is16 ? w_hw[1] : w_hw[2];
    assign w_b        = o_i0_is16 ? w_hw[2] : w_hw[3];
    assign o_i1_is16  = is_rvc(w_a.hw[1:0]);
    assign o_i1_valid = o_i0_valid & ~o_i0_fault & w_a.v & (o_i1_is16 | w_b.v);
    assign o_i1_fault = w_a.err | (~o_i1_is16 & w_b.err);
    assign o_i1_pc    = w_a.pc;
    assign o_i1_instr = o_i1_is16 ? {16'h0000, w_a.hw} : {w_b.hw, w_a.hw};
    assign w_len1     = o_i1_is16 ? 3'd1 : 3'd2;

    // Takes only count for valid slots and never while the buffer is being cleared.
    assign w_take0  = i_i0_take & o_i0_valid & ~i_hold;
    assign w_take1  = w_take0 & i_i1_take & o_i1_valid;
    assign w_e0_cnt = {2'b00, i_win[0].hv[1]} + {2'b00, i_win[0].hv[0]};

    // A faulted i0 drains the rest of its own entry, whatever its length.
    assign w_taken = (w_take0 ? (o_i0_fault ? w_e0_cnt : w_len0) : 3'd0)
                   + (w_take1 ? w_len1 : 3'd0);

    // Attribute each taken stream slot back to the window entry it came from.
    always_comb begin : p_used
        o_used = '0;
        for (int j = 0; j < 4; j++) begin
            if ((3'(j) < w_taken) && w_hw[j].v) begin
                o_used[w_hw[j].ent] = o_used[w_hw[j].ent] + 2'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/el2_ifu_fetch_buf_aln.sv
`default_nettype none
// ============================================================================
//  Module      : el2_ifu_fetch_buf_aln
//  Description : 4-entry fetch buffer with a two-wide RV32IC aligner. Holds
//                storage, pointers, occupancy, consume reporting and the
//                sticky overflow flag.
//  Revision    : 1.0  initial release
// ============================================================================
module el2_ifu_fetch_buf_aln
    import el2_ifu_pkg::fb_entry_t;
#(
    parameter int FB_DEPTH = el2_ifu_pkg::FB_DEPTH,
    parameter int FB_PTR_W = el2_ifu_pkg::FB_PTR_W
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ifc_fetch_req_f,
    input  logic [30:0] ifc_fetch_addr_f,
    input  logic        ic_hit_f,
    input  logic [31:0] ic_rd_data_f,
    input  logic        ic_access_fault_f,
    input  logic        exu_flush_final,
    input  logic        dec_i0_take,
    input  logic        dec_i1_take,
    output logic        i0_valid,
    output logic [31:0] i0_instr,
    output logic [30:0] i0_pc,
    output logic        i0_is16,
    output logic        i0_fault,
    output logic        i1_valid,
    output logic [31:0] i1_instr,
    output logic [30:0] i1_pc,
    output logic        i1_is16,
    output logic        i1_fault,
    output logic        fb_consume1,
    output logic        fb_consume2,
    output logic        fb_overflow
);

    localparam int FB_CNT_W = FB_PTR_W + 1;

    fb_entry_t             r_fb [FB_DEPTH];
    logic [FB_PTR_W-1:0]   r_head;
    logic [FB_PTR_W-1:0]   r_tail;
    logic [FB_CNT_W-1:0]   r_count;
    logic                  r_overflow;

    fb_entry_t [2:0]       w_win;
    logic [FB_PTR_W-1:0]   w_idx    [3];
    logic [2:0][1:0]       w_used;
    logic [1:0]            w_cnt    [3];
    logic [1:0]            w_new_hv [3];
    logic [2:0]            w_ret;
    logic [1:0]            w_n;
    logic                  w_wr;
    logic                  w_full;
    logic                  w_drop;
    logic                  w_push;
    fb_entry_t             w_new;

    // Present head, head+1, head+2 to the aligner; slots past the occupancy look empty.
    for (genvar k = 0; k < 3; k++) begin : g_win
        assign w_idx[k]    = r_head + FB_PTR_W'(k);
        assign w_win[k]    = (FB_CNT_W'(k) < r_count) ? r_fb[w_idx[k]] : '0;
        assign w_cnt[k]    = {1'b0, w_win[k].hv[1]} + {1'b0, w_win[k].hv[0]};
        assign w_ret[k]    = (w_cnt[k] != 2'd0) && (w_used[k] == w_cnt[k]);
        assign w_new_hv[k] = (w_used[k] == 2'd0)     ? w_win[k].hv :
                             (w_used[k] == w_cnt[k]) ? 2'b00       : 2'b10;
    end

    el2_ifu_aln_extract u_extract (
        .i_win      (w_win),
        .i_i0_take  (dec_i0_take),
        .i_i1_take  (dec_i1_take),
        .i_hold     (exu_flush_final | rst),
        .o_i0_valid (i0_valid),
        .o_i0_instr (i0_instr),
        .o_i0_pc    (i0_pc),
        .o_i0_is16  (i0_is16),
        .o_i0_fault (i0_fault),
        .o_i1_valid (i1_valid),
        .o_i1_instr (i1_instr),
        .o_i1_pc    (i1_pc),
        .o_i1_is16  (i1_is16),
        .o_i1_fault (i1_fault),
        .o_used     (w_used)
    );

    // Emptied entries always form a prefix of the window, so the retire count is a prefix length.
    assign w_n = {1'b0, w_ret[0]}
               + {1'b0, w_ret[0] & w_ret[1]}
               + {1'b0, w_ret[0] & w_ret[1] & w_ret[2]};

    assign fb_consume1 = (w_n == 2'd1);
    assign fb_consume2 = (w_n == 2'd2);
    assign fb_overflow = r_overflow;

    // Occupancy before this cycle's consume decides fullness; a same-cycle retire frees the tail slot.
    assign w_wr   = ifc_fetch_req_f & ic_hit_f & ~exu_flush_final;
    assign w_full = (r_count == FB_CNT_W'(FB_DEPTH));
    assign w_drop = w_wr & w_full & (w_n == 2'd0);
    assign w_push = w_wr & ~w_drop;

    assign w_new.data = ic_rd_data_f;
    assign w_new.pc   = ifc_fetch_addr_f[30:1];
    assign w_new.hv   = ifc_fetch_addr_f[0] ? 2'b10 : 2'b11;
    assign w_new.err  = ic_access_fault_f;

    // Buffer state: reset/flush clear occupancy; otherwise apply consume, then write at the tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FB_DEPTH; i++) begin
                r_fb[i].hv <= 2'b00;
            end
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (exu_flush_final) begin
            for (int i = 0; i < FB_DEPTH; i++) begin
                r_fb[i].hv <= 2'b00;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (w_used[k] != 2'd0) begin
                    r_fb[w_idx[k]].hv <= w_new_hv[k];
                end
            end
            if (w_push) begin
                r_fb[r_tail] <= w_new;
            end
            r_head  <= r_head + FB_PTR_W'(w_n);
            r_tail  <= r_tail + FB_PTR_W'(w_push);
            r_count <= r_count + FB_CNT_W'(w_push) - FB_CNT_W'(w_n);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_el2_ifu_fetch_buf_aln.sv
`default_nettype none
// ============================================================================
//  Module      : tb_el2_ifu_fetch_buf_aln
//  Description : Self-checking bench: directed cases with literal results,
//                then randomized traffic against a queue-based model.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_el2_ifu_fetch_buf_aln;

    logic        clk = 1'b0;
    logic        rst, req, hit, afault, flush, tk0, tk1;
    logic [30:0] addr;
    logic [31:0] rdata;
    logic        i0_valid, i0_is16, i0_fault, i1_valid, i1_is16, i1_fault;
    logic [31:0] i0_instr, i1_instr;
    logic [30:0] i0_pc, i1_pc;
    logic        fb_consume1, fb_consume2, fb_overflow;

    always #5 clk = ~clk;

    el2_ifu_fetch_buf_aln dut (
        .clk               (clk),
        .rst               (rst),
        .ifc_fetch_req_f   (req),
        .ifc_fetch_addr_f  (addr),
        .ic_hit_f          (hit),
        .ic_rd_data_f      (rdata),
        .ic_access_fault_f (afault),
        .exu_flush_final   (flush),
        .dec_i0_take       (tk0),
        .dec_i1_take       (tk1),
        .i0_valid          (i0_valid),
        .i0_instr          (i0_instr),
        .i0_pc             (i0_pc),
        .i0_is16           (i0_is16),
        .i0_fault          (i0_fault),
        .i1_valid          (i1_valid),
        .i1_instr          (i1_instr),
        .i1_pc             (i1_pc),
        .i1_is16           (i1_is16),
        .i1_fault          (i1_fault),
        .fb_consume1       (fb_consume1),
        .fb_consume2       (fb_consume2),
        .fb_overflow       (fb_overflow)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] data;
        logic [30:0] base;   // halfword address of halfword 0
        logic [1:0]  hv;
        logic        err;
    } ment_t;

    ment_t       mq[$];
    logic        m_ovf = 1'b0;
    logic        e_v0, e_v1, e_16_0, e_16_1, e_f0, e_f1;
    logic [31:0] e_i0, e_i1;
    logic [30:0] e_pc0, e_pc1;
    int          e_H = 0;
    int          e_n = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    bit          started = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    endtask

    // Expected outputs from the buffer contents and this cycle's takes.
    task automatic model_eval();
        logic [15:0] hd[$];
        logic [30:0] hp[$];
        logic        he[$];
        int len0, len1, rem, c;
        len0 = 1; len1 = 1;
        for (int e = 0; e < mq.size() && e < 3; e++) begin
            for (int h = 0; h < 2; h++) begin
                if (mq[e].hv[h]) begin
                    hd.push_back(h == 0 ? mq[e].data[15:0] : mq[e].data[31:16]);
                    hp.push_back(mq[e].base + 31'(h));
                    he.push_back(mq[e].err);
                end
            end
        end
        e_v0 = 0; e_v1 = 0; e_f0 = 0; e_f1 = 0; e_16_0 = 0; e_16_1 = 0;
        e_i0 = 0; e_i1 = 0; e_pc0 = 0; e_pc1 = 0;
        if (hd.size() >= 1) begin
            e_16_0 = (hd[0][1:0] != 2'b11);
            len0 = e_16_0 ? 1 : 2;
            if (hd.size() >= len0) begin
                e_v0  = 1;
                e_pc0 = hp[0];
                e_i0  = e_16_0 ? {16'h0, hd[0]} : {hd[1], hd[0]};
                e_f0  = he[0];
                if (!e_16_0 && he[1]) e_f0 = 1;
            end
        end
        if (e_v0 && !e_f0 && hd.size() > len0) begin
            e_16_1 = (hd[len0][1:0] != 2'b11);
            len1 = e_16_1 ? 1 : 2;
            if (hd.size() >= len0 + len1) begin
                e_v1  = 1;
                e_pc1 = hp[len0];
                e_i1  = e_16_1 ? {16'h0, hd[len0]} : {hd[len0+1], hd[len0]};
                e_f1  = he[len0];
                if (!e_16_1 && he[len0+1]) e_f1 = 1;
            end
        end
        e_H = 0;
        if (tk0 && e_v0 && !rst && !flush) begin
            e_H = e_f0 ? $countones(mq[0].hv) : len0;
            if (tk1 && e_v1) e_H += len1;
        end
        rem = e_H; e_n = 0;
        for (int e = 0; e < mq.size() && e < 3 && rem > 0; e++) begin
            c = $countones(mq[e].hv);
            if (rem >= c) begin e_n++; rem -= c; end
            else break;
        end
    endtask

    // State update at the clock edge.
    task automatic model_step();
        int pre, nret;
        ment_t t;
        if (rst) begin
            mq.delete(); m_ovf = 1'b0;
        end else if (flush) begin
            mq.delete();
        end else begin
            pre = mq.size(); nret = 0;
            for (int j = 0; j < e_H; j++) begin
                t = mq[0];
                if (t.hv[0]) t.hv[0] = 1'b0; else t.hv[1] = 1'b0;
                if (t.hv == 2'b00) begin void'(mq.pop_front()); nret++; end
                else mq[0] = t;
            end
            if (req && hit) begin
                if (pre == 4 && nret == 0) m_ovf = 1'b1;
                else begin
                    t.data = rdata;
                    t.base = {addr[30:1], 1'b0};
                    t.hv   = addr[0] ? 2'b10 : 2'b11;
                    t.err  = afault;
                    mq.push_back(t);
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("i0_valid", 32'(i0_valid), 32'(e_v0));
        if (e_v0) begin
            chk("i0_instr", i0_instr, e_i0);
            chk("i0_pc", 32'(i0_pc), 32'(e_pc0));
            chk("i0_is16", 32'(i0_is16), 32'(e_16_0));
            chk("i0_fault", 32'(i0_fault), 32'(e_f0));
        end
        chk("i1_valid", 32'(i1_valid), 32'(e_v1));
        if (e_v1) begin
            chk("i1_instr", i1_instr, e_i1);
            chk("i1_pc", 32'(i1_pc), 32'(e_pc1));
            chk("i1_is16", 32'(i1_is16), 32'(e_16_1));
            chk("i1_fault", 32'(i1_fault), 32'(e_f1));
        end
        chk("consume1", 32'(fb_consume1), 32'(e_n == 1));
        chk("consume2", 32'(fb_consume2), 32'(e_n == 2));
        chk("overflow", 32'(fb_overflow), 32'(m_ovf));
    endtask

    // One cycle: finish previous edge, drive inputs, then compare against the model.
    task automatic cyc(input logic r, input logic rq, input logic ht, input logic [31:0] a,
                       input logic [31:0] d, input logic er, input logic fl,
                       input logic t0, input logic t1);
        bit do_cmp;
        do_cmp = started;
        if (started) begin
            @(posedge clk);
            model_step();
        end
        started = 1;
        @(negedge clk);
        rst = r; req = rq; hit = ht; addr = a[31:1]; rdata = d;
        afault = er; flush = fl; tk0 = t0; tk1 = t1;
        #1;
        model_eval();
        if (do_cmp) compare_all();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic t0, input logic t1);
        cyc(1'b0, 1'b1, 1'b1, a, d, 1'b0, 1'b0, t0, t1);
    endtask

    task automatic idle(input logic t0, input logic t1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, t0, t1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] na, tmp, d;
        logic r, fl, rq, ht, er, t0, t1;
        rst = 1; req = 0; hit = 0; addr = 0; rdata = 0; afault = 0; flush = 0; tk0 = 0; tk1 = 0;

        // reset state
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        chk("rst_i0_valid", 32'(i0_valid), 32'd0);
        chk("rst_overflow", 32'(fb_overflow), 32'd0);

        // aligned 16/16/32 stream
        wr(32'h1000, 32'h4501_4581, 1'b0, 1'b0);
        chk("lat_i0_valid", 32'(i0_valid), 32'd0);
        wr(32'h1004, 32'h0000_0513, 1'b1, 1'b1);
        chk("a_i0_instr", i0_instr, 32'h0000_4581);
        chk("a_i0_pc", 32'(i0_pc), 32'h800);
        chk("a_i1_instr", i1_instr, 32'h0000_4501);
        chk("a_i1_pc", 32'(i1_pc), 32'h801);
        chk("a_consume1", 32'(fb_consume1), 32'd1);
        idle(1'b1, 1'b0);
        chk("b_i0_instr", i0_instr, 32'h0000_0513);
        chk("b_i0_pc", 32'(i0_pc), 32'h802);
        chk("b_i0_is16", 32'(i0_is16), 32'd0);
        chk("b_consume1", 32'(fb_consume1), 32'd1);

        // straddle plus incomplete 32-bit wait
        wr(32'h2002, 32'h0513_0000, 1'b0, 1'b0);
        idle(1'b1, 1'b1);
        chk("inc_i0_valid", 32'(i0_valid), 32'd0);
        idle(1'b1, 1'b0);
        chk("inc2_i0_valid", 32'(i0_valid), 32'd0);
        wr(32'h2004, 32'h4581_0000, 1'b0, 1'b0);
        idle(1'b1, 1'b1);
        chk("s_i0_instr", i0_instr, 32'h0000_0513);
        chk("s_i0_pc", 32'(i0_pc), 32'h1001);
        chk("s_i1_instr", i1_instr, 32'h0000_4581);
        chk("s_i1_pc", 32'(i1_pc), 32'h1003);
        chk("s_consume2", 32'(fb_consume2), 32'd1);

        // fault
        cyc(1'b0, 1'b1, 1'b1, 32'h4000, 32'h0000_0513, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 1'b1);
        chk("f_i0_fault", 32'(i0_fault), 32'd1);
        chk("f_i1_valid", 32'(i1_valid), 32'd0);
        chk("f_consume1", 32'(fb_consume1), 32'd1);

        // full: write with a one-entry consume is accepted, then a plain write overflows
        for (int i = 0; i < 4; i++) wr(32'h5000 + 32'(4*i), 32'h0001_0001, 1'b0, 1'b0);
        wr(32'h5010, 32'h0001_0001, 1'b1, 1'b1);
        chk("full_consume1", 32'(fb_consume1), 32'd1);
        idle(1'b0, 1'b0);
        chk("full_no_ovf", 32'(fb_overflow), 32'd0);
        wr(32'h5014, 32'h0001_0001, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        chk("ovf_set", 32'(fb_overflow), 32'd1);
        chk("ovf_head_pc", 32'(i0_pc), 32'h2802);

        // reset in the middle of a straddle
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        wr(32'h6002, 32'h0513_0000, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h6004, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        chk("rstmid_i0_valid", 32'(i0_valid), 32'd0);
        chk("rstmid_overflow", 32'(fb_overflow), 32'd0);

        // flush with a same-cycle write
        wr(32'h7000, 32'h0001_0001, 1'b0, 1'b0);
        wr(32'h7004, 32'h0001_0001, 1'b0, 1'b0);
        wr(32'h7008, 32'h0001_0001, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h700C, 32'h0001_0001, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("fl_i0_valid_cur", 32'(i0_valid), 32'd1);
        idle(1'b0, 1'b0);
        chk("fl_i0_valid", 32'(i0_valid), 32'd0);
        wr(32'h7100, 32'h0001_0001, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        chk("fl_new_head_pc", 32'(i0_pc), 32'h3880);

        // randomized traffic: sequential fetch, redirects only after flush/reset
        na = 32'h7104;
        for (int c = 0; c < 4000; c++) begin
            r  = ($urandom_range(0, 199) == 0);
            fl = !r && ($urandom_range(0, 99) < 3);
            rq = ($urandom_range(0, 99) < 60);
            ht = ($urandom_range(0, 9) != 0);
            d  = $urandom;
            er = ($urandom_range(0, 99) < 4);
            t0 = !r && !fl && ($urandom_range(0, 9) < 7);
            t1 = !r && !fl && ($urandom_range(0, 9) < 6);
            cyc(r, rq, ht, na, d, er, fl, t0, t1);
            if (r || fl) begin
                tmp = $urandom;
                na  = tmp & 32'hFFFF_FFFE;
            end else if (rq && ht) begin
                na = (na & 32'hFFFF_FFFC) + 32'd4;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
